// File: rtl/i2s_rcv_pkg.sv
// Shared I2S helpers: bit-width function and receive state encodings.
// Combinational only; no latency, no flow control.
package i2s_rcv_pkg;

    // Number of bits needed to hold 'value' (minimum 1).
    function automatic int clogb2(input int value);
        int n;
        n = 0;
        for (int v = value; v > 0; v = v >> 1) begin
            n = n + 1;
        end
        if (n < 1) begin
            n = 1;
        end
        return n;
    endfunction

    typedef enum logic [2:0] {
        RCV_IDLE   = 3'd0,
        RCV_LEFT   = 3'd1,
        RCV_WAIT_R = 3'd2,
        RCV_RIGHT  = 3'd3,
        RCV_WAIT_L = 3'd4
    } rcv_state_t;

endpackage

// File: rtl/i2s_lr_edge.sv
// lrclk edge detector sampled on BCLK rising strobes; detect outputs are
// combinational in the strobe cycle; no backpressure.
module i2s_lr_edge (
    input  logic clk,
    input  logic rst,
    input  logic CBrise,
    input  logic lrclk,
    output logic fall_det,
    output logic rise_det
);

    logic lr_prev;

    // Reset high so a low lrclk on the first strobe counts as a left-word start.
    always_ff @(posedge clk) begin
        if (rst) begin
            lr_prev <= 1'b1;
        end else if (CBrise) begin
            lr_prev <= lrclk;
        end
    end

    assign fall_det = CBrise &  lr_prev & ~lrclk;
    assign rise_det = CBrise & ~lr_prev &  lrclk;

endmodule

// File: rtl/i2s_rcv.sv
// I2S receiver: left/right words packed into 'sample'; valid 2 clk after right LSB.
// rcv_rdy/rcv_ack handoff; an unacked pair is overwritten and overrun pulses.
module i2s_rcv
    import i2s_rcv_pkg::*;
#(
    parameter int DATA_BITS = 32,
    parameter int TPD       = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 lrclk,
    input  logic                 CBrise,
    input  logic                 inbit,
    output logic [DATA_BITS-1:0] sample,
    output logic                 rcv_rdy,
    input  logic                 rcv_ack,
    output logic                 overrun,
    output logic                 sync_err
);

    localparam int NB  = DATA_BITS / 2;
    localparam int BCW = clogb2(NB - 1);
    localparam logic [BCW-1:0] BC_LOAD = BCW'(NB - 1);

    if ((DATA_BITS % 2) != 0 || DATA_BITS < 4 || TPD < 0) begin : g_bad_param
        $error("i2s_rcv: DATA_BITS must be even and at least 4");
    end

    logic                 fall_det;
    logic                 rise_det;
    rcv_state_t           state, state_nx;
    logic [BCW-1:0]       bit_count, bit_count_nx;
    logic [NB-1:0]        shreg, shifted, left_hold;
    logic                 left_ok, left_ok_nx;
    logic                 left_latch, done_set, sync_err_c;
    logic                 pair_done;
    logic [DATA_BITS-1:0] pair_dat;

    i2s_lr_edge u_edge (
        .clk      (clk),
        .rst      (rst),
        .CBrise   (CBrise),
        .lrclk    (lrclk),
        .fall_det (fall_det),
        .rise_det (rise_det)
    );

    // left_ok marks that left_hold belongs to the current frame, so a right
    // word following a truncated left word never produces a pair.
    always_comb begin
        state_nx     = state;
        bit_count_nx = bit_count;
        left_ok_nx   = left_ok;
        left_latch   = 1'b0;
        done_set     = 1'b0;
        sync_err_c   = 1'b0;
        shifted      = {shreg[NB-2:0], inbit};
        if (CBrise) begin
            case (state)
                RCV_IDLE: begin
                    if (fall_det) begin
                        state_nx     = RCV_LEFT;
                        bit_count_nx = BC_LOAD;
                    end
                end
                RCV_LEFT: begin
                    if (bit_count == '0) begin
                        left_latch = 1'b1;
                        left_ok_nx = 1'b1;
                        if (rise_det) begin
                            state_nx     = RCV_RIGHT;
                            bit_count_nx = BC_LOAD;
                        end else begin
                            state_nx = RCV_WAIT_R;
                        end
                    end else if (rise_det) begin
                        sync_err_c   = 1'b1;
                        left_ok_nx   = 1'b0;
                        state_nx     = RCV_RIGHT;
                        bit_count_nx = BC_LOAD;
                    end else begin
                        bit_count_nx = bit_count - 1'b1;
                    end
                end
                RCV_WAIT_R: begin
                    if (rise_det) begin
                        state_nx     = RCV_RIGHT;
                        bit_count_nx = BC_LOAD;
                    end else if (fall_det) begin
                        sync_err_c   = 1'b1;
                        state_nx     = RCV_LEFT;
                        bit_count_nx = BC_LOAD;
                    end
                end
                RCV_RIGHT: begin
                    if (bit_count == '0) begin
                        done_set = left_ok;
                        if (fall_det) begin
                            state_nx     = RCV_LEFT;
                            bit_count_nx = BC_LOAD;
                        end else begin
                            state_nx = RCV_WAIT_L;
                        end
                    end else if (fall_det) begin
                        sync_err_c   = 1'b1;
                        state_nx     = RCV_LEFT;
                        bit_count_nx = BC_LOAD;
                    end else begin
                        bit_count_nx = bit_count - 1'b1;
                    end
                end
                RCV_WAIT_L: begin
                    if (fall_det) begin
                        state_nx     = RCV_LEFT;
                        bit_count_nx = BC_LOAD;
                    end else if (rise_det) begin
                        sync_err_c = 1'b1;
                        state_nx   = RCV_IDLE;
                    end
                end
                default: state_nx = RCV_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RCV_IDLE;
            bit_count <= '0;
            shreg     <= '0;
            left_hold <= '0;
            left_ok   <= 1'b0;
            pair_done <= 1'b0;
            pair_dat  <= '0;
        end else begin
            state     <= state_nx;
            bit_count <= bit_count_nx;
            left_ok   <= left_ok_nx;
            pair_done <= done_set;
            if (CBrise && (state == RCV_LEFT || state == RCV_RIGHT)) begin
                shreg <= shifted;
            end
            if (left_latch) begin
                left_hold <= shifted;
            end
            if (done_set) begin
                pair_dat <= {left_hold, shifted};
            end
        end
    end

    // A pair landing in the same cycle as an ack wins: rcv_rdy stays set.
    always_ff @(posedge clk) begin
        if (rst) begin
            sample  <= '0;
            rcv_rdy <= 1'b0;
        end else if (pair_done) begin
            sample  <= pair_dat;
            rcv_rdy <= 1'b1;
        end else if (rcv_ack) begin
            rcv_rdy <= 1'b0;
        end
    end

    assign overrun  = ~rst & pair_done & rcv_rdy & ~rcv_ack;
    assign sync_err = ~rst & sync_err_c;

endmodule

// File: tb/tb_i2s_rcv.sv
// Drives one 64*fs I2S stream into a 16-bit-word and a 24-bit-word receiver
// and checks both against pairs computed directly from the sent slot words.
module tb_i2s_rcv;

    logic        clk;
    logic        rst;
    logic        lrclk;
    logic        CBrise;
    logic        inbit;
    logic        ack32, ack48;
    logic [31:0] sample32;
    logic [47:0] sample48;
    logic        rdy32, rdy48;
    logic        ov32_o, ov48_o, se32_o, se48_o;

    i2s_rcv #(.DATA_BITS(32), .TPD(5)) dut32 (
        .clk      (clk),
        .rst      (rst),
        .lrclk    (lrclk),
        .CBrise   (CBrise),
        .inbit    (inbit),
        .sample   (sample32),
        .rcv_rdy  (rdy32),
        .rcv_ack  (ack32),
        .overrun  (ov32_o),
        .sync_err (se32_o)
    );

    i2s_rcv #(.DATA_BITS(48), .TPD(5)) dut48 (
        .clk      (clk),
        .rst      (rst),
        .lrclk    (lrclk),
        .CBrise   (CBrise),
        .inbit    (inbit),
        .sample   (sample48),
        .rcv_rdy  (rdy48),
        .rcv_ack  (ack48),
        .overrun  (ov48_o),
        .sync_err (se48_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   errs   = 0;
    int   checks = 0;
    int   ncyc   = 0;
    int   se32, se48, ov32, ov48, low32, low48;
    int   rise32, rise48, lsb32, lsb48;
    logic rdy32_q = 1'b0;
    logic rdy48_q = 1'b0;
    logic carry   = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        se32 = 0; se48 = 0; ov32 = 0; ov48 = 0; low32 = 0; low48 = 0;
        rise32 = -1; rise48 = -1; lsb32 = -1; lsb48 = -1;
    endtask

    // One system clock: drive inputs after the falling edge, observe 1 ns later.
    task automatic cyc(input logic lr, input logic cb, input logic b,
                       input logic a32, input logic a48);
        @(negedge clk);
        lrclk = lr; CBrise = cb; inbit = b; ack32 = a32; ack48 = a48;
        #1;
        ncyc++;
        if (se32_o) se32++;
        if (se48_o) se48++;
        if (ov32_o) ov32++;
        if (ov48_o) ov48++;
        if (!rdy32) low32++;
        if (!rdy48) low48++;
        if (rdy32 && !rdy32_q) rise32 = ncyc;
        if (rdy48 && !rdy48_q) rise48 = ncyc;
        rdy32_q = rdy32;
        rdy48_q = rdy48;
    endtask

    // One I2S slot of nb BCLKs (4 clk each); bit j>=1 carries w[32-j], bit 0 is
    // the previous slot's trailing bit. Optional ack in the clk after strobe aj.
    task automatic send_slot(input logic lr, input logic [31:0] w, input int nb,
                             input int a32j, input int a48j);
        for (int j = 0; j < nb; j++) begin
            logic b;
            if (j == 0) b = carry;
            else b = w[32 - j];
            cyc(lr, 1'b1, b, 1'b0, 1'b0);
            if (lr && j == 16) lsb32 = ncyc;
            if (lr && j == 24) lsb48 = ncyc;
            cyc(lr, 1'b0, b, j == a32j, j == a48j);
            cyc(lr, 1'b0, b, 1'b0, 1'b0);
            cyc(lr, 1'b0, b, 1'b0, 1'b0);
        end
        carry = w[32 - nb];
    endtask

    task automatic pair(input logic [31:0] l, input logic [31:0] r,
                        input int a32j, input int a48j);
        send_slot(1'b0, l, 32, -1, -1);
        send_slot(1'b1, r, 32, a32j, a48j);
    endtask

    task automatic ack_both();
        cyc(lrclk, 1'b0, 1'b0, 1'b1, 1'b1);
        cyc(lrclk, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    function automatic logic [31:0] exp32(input logic [31:0] l, input logic [31:0] r);
        return {l[31:16], r[31:16]};
    endfunction

    function automatic logic [47:0] exp48(input logic [31:0] l, input logic [31:0] r);
        return {l[31:8], r[31:8]};
    endfunction

    initial begin
        logic [31:0] l, r;
        logic [31:0] hold32;
        rst = 1'b1; lrclk = 1'b1; CBrise = 1'b0; inbit = 1'b0; ack32 = 1'b0; ack48 = 1'b0;
        clr();
        repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset_sample32", sample32, 0);
        chk("reset_rdy32", rdy32, 0);
        chk("reset_sample48", sample48, 0);
        chk("reset_rdy48", rdy48, 0);
        chk("reset_pulses", {ov32_o, se32_o, ov48_o, se48_o}, 0);
        rst = 1'b0;

        // Basic pair, preceded by a right slot that must be discarded.
        clr();
        send_slot(1'b1, $urandom, 32, -1, -1);
        l = {16'hA5C3, 16'($urandom)};
        r = {16'h1234, 16'($urandom)};
        pair(l, r, -1, -1);
        chk("basic_sample32", sample32, 32'hA5C31234);
        chk("basic_rdy32", rdy32, 1);
        chk("basic_lat32", rise32 - lsb32, 2);
        chk("basic_sample48", sample48, exp48(l, r));
        chk("basic_lat48", rise48 - lsb48, 2);
        chk("basic_no_pulses", se32 + se48 + ov32 + ov48, 0);

        // Second pair with no ack overwrites and flags one overrun.
        clr();
        l = {16'hFFFF, 16'($urandom)};
        r = {16'h0001, 16'($urandom)};
        pair(l, r, -1, -1);
        chk("ovr_count32", ov32, 1);
        chk("ovr_sample32", sample32, 32'hFFFF0001);
        chk("ovr_rdy32", rdy32, 1);
        chk("ovr_count48", ov48, 1);
        chk("ovr_sample48", sample48, exp48(l, r));

        // Ack lands in the pair_done cycle: rdy never drops, no overrun.
        clr();
        l = $urandom; r = $urandom;
        pair(l, r, 16, 24);
        chk("simack_rdy_low32", low32, 0);
        chk("simack_sample32", sample32, exp32(l, r));
        chk("simack_ovr32", ov32, 0);
        chk("simack_rdy_low48", low48, 0);
        chk("simack_sample48", sample48, exp48(l, r));
        chk("simack_ovr48", ov48, 0);
        ack_both();
        chk("ack_clear32", rdy32, 0);
        chk("ack_clear48", rdy48, 0);
        hold32 = sample32;
        ack_both();
        chk("stray_ack_rdy32", rdy32, 0);
        chk("stray_ack_sample32", sample32, hold32);

        // Left word cut after 10 bits; the orphan right word must not pair.
        clr();
        send_slot(1'b0, $urandom, 11, -1, -1);
        send_slot(1'b1, {16'h00FF, 16'($urandom)}, 32, -1, -1);
        chk("trunc_serr32", se32, 1);
        chk("trunc_serr48", se48, 1);
        chk("trunc_norpair32", rdy32, 0);
        chk("trunc_norpair48", rdy48, 0);
        l = {16'h8001, 16'($urandom)};
        r = {16'h00FF, 16'($urandom)};
        pair(l, r, -1, -1);
        chk("resync_sample32", sample32, 32'h800100FF);
        chk("resync_rdy32", rdy32, 1);
        chk("resync_sample48", sample48, exp48(l, r));
        chk("resync_serr_total", se32 + se48, 2);

        // Reset in the middle of a right word.
        clr();
        send_slot(1'b0, $urandom, 32, -1, -1);
        send_slot(1'b1, $urandom, 9, -1, -1);
        rst = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("midrst_sample32", sample32, 0);
        chk("midrst_rdy32", rdy32, 0);
        chk("midrst_sample48", sample48, 0);
        chk("midrst_rdy48", rdy48, 0);
        chk("midrst_pulses", {ov32_o, se32_o, ov48_o, se48_o}, 0);
        clr();
        send_slot(1'b1, $urandom, 32, -1, -1);
        l = {16'h1111, 16'($urandom)};
        r = {16'h2222, 16'($urandom)};
        pair(l, r, -1, -1);
        chk("postrst_sample32", sample32, 32'h11112222);
        chk("postrst_rdy32", rdy32, 1);
        chk("postrst_sample48", sample48, exp48(l, r));
        chk("postrst_pulses", se32 + se48 + ov32 + ov48, 0);

        // Random pairs, each acked beforehand so no overrun is expected.
        clr();
        for (int k = 0; k < 4; k++) begin
            ack_both();
            l = $urandom; r = $urandom;
            pair(l, r, -1, -1);
            chk("rand_sample32", sample32, exp32(l, r));
            chk("rand_sample48", sample48, exp48(l, r));
            chk("rand_rdy", {rdy32, rdy48}, 2'b11);
        end
        chk("rand_pulses", se32 + se48 + ov32 + ov48, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/i2s_rcv.md
# i2s_rcv

I2S receiver: deserialises a two-channel I2S bit stream into one `DATA_BITS`-wide word, with left in the upper half and right in the lower half. It is the receive counterpart of the I2S transmit path and sits between a codec's serial data output and the sample consumer. It runs on the system clock and uses the same BCLK edge strobe and lrclk as the transmit side. A completed left/right pair is handed off with a ready/ack handshake.

## Interface
- `DATA_BITS`, 32, total bits per left+right pair; must be even. NB = DATA_BITS/2 bits per channel.
- `TPD`, 5, simulation-only assignment delay on registered outputs.
- `clk` input 1: system clock; all logic is on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `lrclk` input 1: left/right clock, synchronous to clk. Low selects left, high selects right.
- `CBrise` input 1: one-clk strobe marking each BCLK rising edge; all bit sampling happens only on these cycles.
- `inbit` input 1: serial data from the codec, stable on CBrise cycles.
- `sample` output DATA_BITS: last completed pair, {left[NB-1:0], right[NB-1:0]}.
- `rcv_rdy` output 1: a new pair is waiting in `sample`.
- `rcv_ack` input 1: consumer has taken `sample`.
- `overrun` output 1: one-clk pulse when a new pair overwrites an unacknowledged one.
- `sync_err` output 1: one-clk pulse when an lrclk edge truncates a word.

## Operation
- `lr_prev` register: updated from lrclk on every CBrise cycle.
- Edge detection runs on CBrise cycles only.
  - fall_det: lr_prev=1, lrclk=0.
  - rise_det: lr_prev=0, lrclk=1.
- I2S alignment: the MSB arrives on the 2nd BCLK rising edge after an lrclk edge. The detecting CBrise is the 1st edge, so the next CBrise samples the MSB.
- Shift register `shreg` [NB-1:0] shifts MSB first: shreg <= {shreg[NB-2:0], inbit}. `bit_count` [clogb2(NB-1)-1:0] counts down the bits of the current word.
- State machine, evaluated on CBrise cycles; the state holds otherwise:
  - RCV_IDLE: wait for fall_det, then load bit_count=NB-1 and go to RCV_LEFT. Any data before the first left word is discarded.
  - RCV_LEFT: on each CBrise, shift in inbit.
    - bit_count=0: latch left_hold <= shifted value and go to RCV_WAIT_R.
    - Otherwise decrement bit_count.
    - rise_det before completion: pulse sync_err, load bit_count=NB-1, go to RCV_RIGHT (resync on the right word).
  - RCV_WAIT_R: on rise_det, load bit_count=NB-1 and go to RCV_RIGHT. On fall_det (right half missing), pulse sync_err and restart RCV_LEFT.
  - RCV_RIGHT: shift as in RCV_LEFT.
    - bit_count=0: raise `pair_done` for one clk and go to RCV_WAIT_L.
    - fall_det before completion: pulse sync_err and go to RCV_LEFT. The partial pair is dropped.
  - RCV_WAIT_L: on fall_det, go to RCV_LEFT (load NB-1). On rise_det, pulse sync_err and go to RCV_IDLE.
- Bits after the NB-th in a slot (BCLK periods longer than the word) are ignored.
- Output update, one clk after pair_done: sample <= {left_hold, shifted right}, rcv_rdy <= 1.
- rcv_rdy clears on rcv_ack when no pair_done occurs in the same cycle.
- Simultaneous rcv_ack and pair_done: sample updates, rcv_rdy stays 1, no overrun.
- pair_done while rcv_rdy=1 and no rcv_ack: sample is overwritten, rcv_rdy stays 1, overrun pulses for one clk.
- rcv_ack while rcv_rdy=0: ignored.

## Timing
- Reset values: sample=0, rcv_rdy=0, overrun=0, sync_err=0, state=RCV_IDLE, lr_prev=1, shreg=0, bit_count=0.
- Because lr_prev resets to 1, the first fall_det can occur on the first CBrise after reset if lrclk is low.
- Reset mid-word: the partial word is discarded and the next capture starts at a fresh fall_det. rst has priority over every other action.
- Latency: sample and rcv_rdy are valid 2 clk after the CBrise cycle that samples the right LSB (1 clk to pair_done, 1 clk to the output register).
- overrun and sync_err are asserted in the same cycle as the event that causes them, each for exactly one clk.
- Throughput: one pair per lrclk period. The consumer has one full lrclk period to ack before an overrun.

## Structure
- Shared HPSDR package holds:
  - the `clogb2` function, also used by the transmit side;
  - the I2S state encodings RCV_IDLE..RCV_WAIT_L as localparams.
- Natural sub-module: `i2s_lr_edge`, which holds lr_prev and produces fall_det/rise_det qualified by CBrise. It is reusable by the transmit side.
- Everything else stays in one flat module.

## Test plan
- DATA_BITS=32, BCLK = 64·fs: send left 0xA5C3, right 0x1234. Expect sample=0xA5C31234 and rcv_rdy=1, 2 clk after the right LSB.
- Send two back-to-back pairs with no rcv_ack: second pair 0xFFFF/0x0001. Expect one overrun pulse, sample=0xFFFF0001, rcv_rdy=1.
- Assert rcv_ack in the same cycle as pair_done. Expect rcv_rdy held at 1, sample updated, overrun=0.
- Pull lrclk high after 10 left bits. Expect a sync_err pulse; the following right 0x00FF plus next left 0x8001 give sample=0x800100FF only after a complete pair.
- Assert rst for 1 clk in the middle of the right word. Expect all outputs 0; the next clean pair 0x1111/0x2222 gives sample=0x11112222.
- DATA_BITS=48, BCLK = 64·fs (24-bit words, 32-bit slots): send left 0x7FFFFF, right 0x800000. Expect sample=0x7FFFFF800000, with the trailing 8 bits per slot ignored.
